// File: rtl/manch_decoding_if.sv
// Manchester receiver bus: serial line in, decoded word, strobe and status out.
// The master modport is the line/transmit side, the slave modport is the decoder.
interface manch_decoding_if #(
    parameter int WIDTH = 16
);
    logic             rx;
    logic             rx_valid;
    logic [WIDTH-1:0] rx_data;
    logic             rx_err;
    logic             rx_busy;

    modport master (
        output rx,
        input  rx_valid,
        input  rx_data,
        input  rx_err,
        input  rx_busy
    );

    modport slave (
        input  rx,
        output rx_valid,
        output rx_data,
        output rx_err,
        output rx_busy
    );
endinterface

// File: rtl/manch_decoding.sv
// Manchester line receiver/decoder.
// Synchronises rx, detects the start bit on a rising edge of the synchronised
// line, samples every half-bit at its centre and assembles WIDTH bits LSB-first.
// Optional feature macro: MANCH_RX_PARITY_EN adds an odd-parity bit after the
// data bits; it is checked but not output.
module manch_decoding #(
    parameter int WIDTH    = 16,
    parameter int HALF_CYC = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    manch_decoding_if.slave   bus
);

`ifdef MANCH_RX_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int CW = $clog2(HALF_CYC);
    localparam int BW = $clog2(NBITS) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        DONE  = 2'd3
    } state_t;

`ifdef MANCH_RX_PARITY_EN
    // Odd parity holds when data bits plus the parity bit contain an odd count of ones.
    function automatic logic odd_parity_ok(input logic [WIDTH-1:0] d, input logic p);
        return ^{d, p};
    endfunction
`endif

    logic             sync1_r;
    logic             s_r;
    logic             prev_r;
    state_t           state_r;
    state_t           state_nxt_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_nxt_s;
    logic             half_r;
    logic             half_nxt_s;
    logic             first_r;
    logic             first_nxt_s;
    logic [BW-1:0]    bit_cnt_r;
    logic [BW-1:0]    bit_cnt_nxt_s;
    logic [WIDTH-1:0] shreg_r;
    logic [WIDTH-1:0] shreg_nxt_s;
    logic             err_r;
    logic             err_nxt_s;
    logic             sample_s;
    logic             rx_valid_r;
    logic [WIDTH-1:0] rx_data_r;
    logic             rx_err_r;
    logic             rx_busy_r;

    assign sample_s = (cnt_r == {CW{1'b0}});

    // Two-flop synchroniser for the asynchronous line, plus previous value for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            s_r     <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= bus.rx;
            s_r     <= sync1_r;
            prev_r  <= s_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and datapath decisions: start detection, half-bit sampling, bit assembly.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        half_nxt_s    = half_r;
        first_nxt_s   = first_r;
        bit_cnt_nxt_s = bit_cnt_r;
        shreg_nxt_s   = shreg_r;
        err_nxt_s     = err_r;
        case (state_r)
            IDLE: begin
                if (s_r && !prev_r) begin
                    // First sample lands in the centre of the start bit's high half.
                    state_nxt_s   = START;
                    cnt_nxt_s     = CW'(HALF_CYC / 2 - 1);
                    half_nxt_s    = 1'b0;
                    bit_cnt_nxt_s = {BW{1'b0}};
                    err_nxt_s     = 1'b0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                if (sample_s) begin
                    cnt_nxt_s = CW'(HALF_CYC - 1);
                    if (!half_r) begin
                        // A low first half means the edge was only a glitch.
                        if (!s_r) begin
                            state_nxt_s = IDLE;
                        end else begin
                            half_nxt_s = 1'b1;
                        end
                    end else begin
                        // Second half should be low; a high level is a framing error.
                        err_nxt_s   = err_r | s_r;
                        half_nxt_s  = 1'b0;
                        state_nxt_s = DATA;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - CW'(1);
                end
            end
            DATA: begin
                if (sample_s) begin
                    cnt_nxt_s = CW'(HALF_CYC - 1);
                    if (!half_r) begin
                        first_nxt_s = s_r;
                        half_nxt_s  = 1'b1;
                    end else begin
                        half_nxt_s = 1'b0;
                        err_nxt_s  = err_r | (first_r == s_r);
                        if (bit_cnt_r < BW'(WIDTH)) begin
                            shreg_nxt_s            = shreg_r >> 1;
                            shreg_nxt_s[WIDTH-1]   = s_r;
                        end else begin
                            shreg_nxt_s = shreg_r;
                        end
                        if (bit_cnt_r == BW'(NBITS - 1)) begin
                            state_nxt_s = DONE;
`ifdef MANCH_RX_PARITY_EN
                            err_nxt_s   = err_nxt_s | ~odd_parity_ok(shreg_nxt_s, s_r);
`endif
                        end else begin
                            bit_cnt_nxt_s = bit_cnt_r + BW'(1);
                        end
                    end
                end else begin
                    cnt_nxt_s = cnt_r - CW'(1);
                end
            end
            DONE: begin
                err_nxt_s   = 1'b0;
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Datapath registers for sampling and assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= {CW{1'b0}};
            half_r    <= 1'b0;
            first_r   <= 1'b0;
            bit_cnt_r <= {BW{1'b0}};
            shreg_r   <= {WIDTH{1'b0}};
            err_r     <= 1'b0;
        end else begin
            cnt_r     <= cnt_nxt_s;
            half_r    <= half_nxt_s;
            first_r   <= first_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
            shreg_r   <= shreg_nxt_s;
            err_r     <= err_nxt_s;
        end
    end

    // Registered outputs, loaded as the FSM enters DONE so the strobe coincides with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_r <= 1'b0;
            rx_data_r  <= {WIDTH{1'b0}};
            rx_err_r   <= 1'b0;
            rx_busy_r  <= 1'b0;
        end else begin
            rx_valid_r <= (state_nxt_s == DONE);
            rx_busy_r  <= (state_nxt_s == START) || (state_nxt_s == DATA);
            if (state_nxt_s == DONE) begin
                rx_data_r <= shreg_nxt_s;
                rx_err_r  <= err_nxt_s;
            end else begin
                rx_err_r  <= 1'b0;
            end
        end
    end

    assign bus.rx_valid = rx_valid_r;
    assign bus.rx_data  = rx_data_r;
    assign bus.rx_err   = rx_err_r;
    assign bus.rx_busy  = rx_busy_r;

endmodule

// File: tb/tb_manch_decoding.sv
// Self-checking bench for manch_decoding: directed frames drive the line,
// expected words are queued at send time and a monitor checks each strobe.
module tb_manch_decoding;
    localparam int WIDTH = 16;
    localparam int HC    = 8;
`ifdef MANCH_RX_PARITY_EN
    localparam int NSAMP = 2 * (2 + WIDTH);
`else
    localparam int NSAMP = 2 * (1 + WIDTH);
`endif

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             err;
        int               cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    manch_decoding_if #(.WIDTH(WIDTH)) bus ();

    manch_decoding #(.WIDTH(WIDTH), .HALF_CYC(HC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe pops one expectation from the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.rx_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: got rx_valid=1 data=0x%0h, required no strobe", bus.rx_data);
            end else begin
                mon_e = sb_q.pop_front();
                check("rx_data", 32'(bus.rx_data), 32'(mon_e.data));
                check("rx_err", 32'(bus.rx_err), 32'(mon_e.err));
                check("valid_cycle", cyc, mon_e.cyc);
                check("busy_at_valid", 32'(bus.rx_busy), 32'd0);
            end
        end
    end

    task automatic half(input logic v);
        bus.rx = v;
        repeat (HC) @(negedge clk);
    endtask

    // par_mode: 0 = correct odd parity, 1 = force parity bit 1, 2 = force parity bit 0.
    task automatic send(input logic [WIDTH-1:0] d, input int bad_bit, input int par_mode, input int gap);
        exp_t e;
        logic p;
        e.data = d;
        e.err  = 1'b0;
        if (bad_bit >= 0) begin
            e.data[bad_bit] = 1'b1;
            e.err = 1'b1;
        end
        p = ~(^d);
        if (par_mode == 1) p = 1'b1;
        if (par_mode == 2) p = 1'b0;
`ifdef MANCH_RX_PARITY_EN
        if ((^{e.data, p}) == 1'b0) e.err = 1'b1;
`endif
        e.cyc = cyc + 2 + HC / 2 + (NSAMP - 1) * HC + 1;
        sb_q.push_back(e);
        half(1'b1);
        check("busy_in_frame", 32'(bus.rx_busy), 32'd1);
        half(1'b0);
        for (int i = 0; i < WIDTH; i++) begin
            if (i == bad_bit) begin
                half(1'b1);
                half(1'b1);
            end else begin
                half(~d[i]);
                half(d[i]);
            end
        end
`ifdef MANCH_RX_PARITY_EN
        half(~p);
        half(p);
`endif
        for (int g = 0; g < gap; g++) half(1'b0);
    endtask

    // Frame aborted by a reset pulse in the first half of data bit 9.
    task automatic send_abort(input logic [WIDTH-1:0] d);
        half(1'b1);
        half(1'b0);
        for (int i = 0; i < 9; i++) begin
            half(~d[i]);
            half(d[i]);
        end
        bus.rx = ~d[9];
        repeat (HC / 2) @(negedge clk);
        rst_n = 1'b0;
        bus.rx = 1'b0;
        #1;
        check("abort_valid", 32'(bus.rx_valid), 32'd0);
        check("abort_busy", 32'(bus.rx_busy), 32'd0);
        check("abort_data", 32'(bus.rx_data), 32'd0);
        check("abort_err", 32'(bus.rx_err), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4 * HC) @(negedge clk);
        check("abort_busy_after", 32'(bus.rx_busy), 32'd0);
    endtask

    initial begin
        logic saw_busy;
        rst_n  = 1'b0;
        bus.rx = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_valid", 32'(bus.rx_valid), 32'd0);
        check("reset_err", 32'(bus.rx_err), 32'd0);
        check("reset_busy", 32'(bus.rx_busy), 32'd0);
        check("reset_data", 32'(bus.rx_data), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Nominal frame with exact strobe latency.
        send(16'hA5C3, -1, 0, 2);
        // Coding error on data bit 7 (both halves high).
        send(16'h0001, 7, 0, 2);

        // Short glitch: busy pulses, no strobe.
        bus.rx = 1'b1;
        repeat (3) @(negedge clk);
        bus.rx = 1'b0;
        saw_busy = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.rx_busy === 1'b1) saw_busy = 1'b1;
        end
        check("glitch_busy_seen", 32'(saw_busy), 32'd1);
        check("glitch_busy_clear", 32'(bus.rx_busy), 32'd0);
        send(16'h1234, -1, 0, 2);

        // Back-to-back with a single low half-bit between frames.
        send(16'hFFFF, -1, 0, 1);
        send(16'h0000, -1, 0, 2);

        // Reset mid-frame, then a clean frame.
        send_abort(16'h9999);
        send(16'h5A5A, -1, 0, 2);

`ifdef MANCH_RX_PARITY_EN
        send(16'h0003, -1, 1, 2);
        send(16'h0003, -1, 2, 2);
`endif

        for (int i = 0; i < 2000 && sb_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
